// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared SIMPLE core flag, branch-condition and FSM definitions
package simple_pkg;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;
  localparam logic [2:0] COND_B   = 3'b100;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational SZCV branch condition evaluator
// Shared with the non-pipelined core; reserved codes never take.
module branch_cond_eval
  import simple_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);

  logic s_flag;
  logic z_flag;
  logic v_flag;
  logic unused_c;

  assign s_flag   = flags_i[FLAG_S];
  assign z_flag   = flags_i[FLAG_Z];
  assign v_flag   = flags_i[FLAG_V];
  // Carry is architectural state only; no condition reads it.
  assign unused_c = flags_i[FLAG_C];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_BE:  taken_o = z_flag;
      COND_BLT: taken_o = s_flag ^ v_flag;
      COND_BLE: taken_o = z_flag | (s_flag ^ v_flag);
      COND_BNE: taken_o = ~z_flag;
      COND_B:   taken_o = 1'b1;
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// rtl/cond_branch_unit.sv - flag register, branch resolution, redirect and timed flush
// Sits between EX and the fetch PC mux of the pipelined SIMPLE core.
module cond_branch_unit
  import simple_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int BYPASS       = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            flag_we_i,
  input  logic [3:0]      flag_in_i,
  input  logic            br_valid_i,
  input  logic [2:0]      br_cond_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic [3:0]      flags_out_o,
  output logic            br_taken_o,
  output logic [PC_W-1:0] br_pc_o,
  output logic            flush_o,
  output logic            busy_o
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      flags_q, flags_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      eff_flags;
  logic            cond_true;

  // A flag writer in the same cycle is older than the branch.
  assign eff_flags = ((BYPASS != 0) && flag_we_i) ? flag_in_i : flags_q;

  branch_cond_eval u_eval (
    .flags_i (eff_flags),
    .cond_i  (br_cond_i),
    .taken_o (cond_true)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      flags_q <= 4'b0000;
      taken_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      taken_q <= taken_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    taken_d = taken_q;
    pc_d    = pc_q;
    if (!stall_i) begin
      taken_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (flag_we_i) begin
            flags_d = flag_in_i;
          end
          if (br_valid_i && cond_true) begin
            taken_d = 1'b1;
            pc_d    = br_target_i;
            cnt_d   = CNT_INIT;
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          // Wrong-path flag writes and branches are dropped here.
          if (cnt_q == 3'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign flags_out_o = flags_q;
  assign br_taken_o  = taken_q;
  assign br_pc_o     = pc_q;
  assign flush_o     = (state_q == FLUSH);
  assign busy_o      = (state_q == FLUSH);

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb/tb_cond_branch_unit.sv - directed scoreboard bench for cond_branch_unit (BYPASS=1 and 0)
module tb_cond_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;

  logic [3:0]  flags1, flags0;
  logic        taken1, taken0;
  logic [15:0] pc1, pc0;
  logic        flush1, flush0;
  logic        busy1, busy0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic        t1;
    logic        t0;
    logic        f1;
    logic        f0;
    logic [3:0]  flags;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cond_branch_unit #(.PC_W(16), .FLUSH_CYCLES(2), .BYPASS(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flag_we_i(flag_we),
    .flag_in_i(flag_in), .br_valid_i(br_valid), .br_cond_i(br_cond),
    .br_target_i(br_target), .flags_out_o(flags1), .br_taken_o(taken1),
    .br_pc_o(pc1), .flush_o(flush1), .busy_o(busy1)
  );

  cond_branch_unit #(.PC_W(16), .FLUSH_CYCLES(2), .BYPASS(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flag_we_i(flag_we),
    .flag_in_i(flag_in), .br_valid_i(br_valid), .br_cond_i(br_cond),
    .br_target_i(br_target), .flags_out_o(flags0), .br_taken_o(taken0),
    .br_pc_o(pc0), .flush_o(flush0), .busy_o(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    flag_we = 1'b0; flag_in = 4'b0000; br_valid = 1'b0;
    br_cond = 3'b000; br_target = 16'h0000; stall = 1'b0;
  endtask

  // Push the expectation for the edge about to happen, then compare after it.
  task automatic step(input string tag, input logic t1, input logic t0,
                      input logic f1, input logic f0, input logic [3:0] flags,
                      input logic [15:0] pc);
    exp_t e;
    e.tag = tag; e.t1 = t1; e.t0 = t0; e.f1 = f1; e.f0 = f0;
    e.flags = flags; e.pc = pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".taken1"}, 32'(taken1), 32'(e.t1));
    chk({e.tag, ".taken0"}, 32'(taken0), 32'(e.t0));
    chk({e.tag, ".flush1"}, 32'(flush1), 32'(e.f1));
    chk({e.tag, ".busy1"},  32'(busy1),  32'(e.f1));
    chk({e.tag, ".flush0"}, 32'(flush0), 32'(e.f0));
    chk({e.tag, ".busy0"},  32'(busy0),  32'(e.f0));
    chk({e.tag, ".flags1"}, 32'(flags1), 32'(e.flags));
    chk({e.tag, ".flags0"}, 32'(flags0), 32'(e.flags));
    if (e.t1) chk({e.tag, ".pc1"}, 32'(pc1), 32'(e.pc));
    if (e.t0) chk({e.tag, ".pc0"}, 32'(pc0), 32'(e.pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rnd;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.flags1", 32'(flags1), 32'h0);
    chk("rst.flags0", 32'(flags0), 32'h0);
    chk("rst.taken1", 32'(taken1), 32'h0);
    chk("rst.pc1",    32'(pc1),    32'h0);
    chk("rst.flush1", 32'(flush1), 32'h0);
    chk("rst.busy1",  32'(busy1),  32'h0);
    rst_n = 1'b1;

    br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h00ff;
    step("be_nz", 0, 0, 0, 0, 4'b0000, 16'h0);

    idle_inputs(); flag_we = 1'b1; flag_in = 4'b0100;
    step("latch", 0, 0, 0, 0, 4'b0100, 16'h0);
    idle_inputs(); br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h0040;
    step("be_take", 1, 1, 1, 1, 4'b0100, 16'h0040);
    idle_inputs();
    step("be_fl2", 0, 0, 1, 1, 4'b0100, 16'h0);
    step("be_done", 0, 0, 0, 0, 4'b0100, 16'h0);

    flag_we = 1'b1; flag_in = 4'b0000;
    step("clr", 0, 0, 0, 0, 4'b0000, 16'h0);
    flag_we = 1'b1; flag_in = 4'b1000; br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h1234;
    step("blt_byp", 1, 0, 1, 0, 4'b1000, 16'h1234);
    idle_inputs();
    step("blt_fl2", 0, 0, 1, 0, 4'b1000, 16'h0);
    step("blt_done", 0, 0, 0, 0, 4'b1000, 16'h0);
    // Bypassed flags 0000 fail BLE; registered 1000 (S^V) passes it.
    flag_we = 1'b1; flag_in = 4'b0000; br_valid = 1'b1; br_cond = 3'b010; br_target = 16'h5678;
    step("ble_byp", 0, 1, 0, 1, 4'b0000, 16'h5678);
    idle_inputs();
    step("ble_fl2", 0, 0, 0, 1, 4'b0000, 16'h0);
    step("ble_done", 0, 0, 0, 0, 4'b0000, 16'h0);

    br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0010;
    step("b_take", 1, 1, 1, 1, 4'b0000, 16'h0010);
    flag_we = 1'b1; flag_in = 4'b0100; br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0099;
    step("wp_ign", 0, 0, 1, 1, 4'b0000, 16'h0);
    idle_inputs();
    step("wp_done", 0, 0, 0, 0, 4'b0000, 16'h0);

    br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0020;
    step("stl_take", 1, 1, 1, 1, 4'b0000, 16'h0020);
    stall = 1'b1; flag_we = 1'b1; flag_in = 4'b1111; br_target = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stl_hold%0d", i), 1, 1, 1, 1, 4'b0000, 16'h0020);
    end
    idle_inputs();
    step("stl_fl2", 0, 0, 1, 1, 4'b0000, 16'h0);
    step("stl_done", 0, 0, 0, 0, 4'b0000, 16'h0);

    flag_we = 1'b1; flag_in = 4'b0010;
    step("c_store", 0, 0, 0, 0, 4'b0010, 16'h0);
    idle_inputs(); br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0030;
    step("rst_take", 1, 1, 1, 1, 4'b0010, 16'h0030);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("arst.flush1", 32'(flush1), 32'h0);
    chk("arst.busy1",  32'(busy1),  32'h0);
    chk("arst.flush0", 32'(flush0), 32'h0);
    chk("arst.taken1", 32'(taken1), 32'h0);
    chk("arst.flags1", 32'(flags1), 32'h0);
    chk("arst.pc1",    32'(pc1),    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int c = 5; c < 8; c++) begin
      for (int k = 0; k < 3; k++) begin
        rnd = 4'($urandom_range(0, 15));
        flag_we = 1'b1; flag_in = rnd; br_valid = 1'b1;
        br_cond = 3'(c); br_target = 16'hdead;
        step($sformatf("rsv%0d_%0d", c, k), 0, 0, 0, 0, rnd, 16'h0);
      end
    end

    idle_inputs(); flag_we = 1'b1; flag_in = 4'b0000;
    step("bne_clr", 0, 0, 0, 0, 4'b0000, 16'h0);
    idle_inputs(); br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0abc;
    step("bne_take", 1, 1, 1, 1, 4'b0000, 16'h0abc);
    idle_inputs();
    step("bne_fl2", 0, 0, 1, 1, 4'b0000, 16'h0);
    step("bne_done", 0, 0, 0, 0, 4'b0000, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Consumer end of the ALU/shifter condition-code interface in the pipelined SIMPLE core.
- Latches the 4-bit SZCV flags produced in EX and resolves conditional branches against them: B, BE, BLT, BLE, BNE.
- Issues a registered redirect PC and a timed flush of the wrong-path pipeline stages.
- Sits between the EX stage and the fetch PC mux.

Parameters:
- PC_W, 16, width of branch target and redirect PC
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (range 1..7)
- BYPASS, 1, 1 = same-cycle flag_in is forwarded into branch evaluation; 0 = use only the registered flags

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline stall; freezes all state
- flag_we  in  1  the EX instruction writes flags this cycle
- flag_in  in  4  flags from ALU/shifter: [3]=S, [2]=Z, [1]=C, [0]=V
- br_valid  in  1  branch instruction present in EX this cycle
- br_cond  in  3  branch condition field
- br_target  in  PC_W  computed branch target
- flags_out  out  4  current architectural flag register
- br_taken  out  1  one-cycle pulse: redirect fetch
- br_pc  out  PC_W  redirect PC, valid while br_taken=1
- flush  out  1  kill wrong-path instructions in IF/ID
- busy  out  1  high while in FLUSH state

Behaviour:
- Reset (async, rst_n=0): flags_out=4'b0000, br_taken=0, br_pc=0, flush=0, busy=0, state=IDLE, flush counter=0. Takes effect immediately, including mid-flush.
- Effective flags: eff = (BYPASS && flag_we) ? flag_in : flags_out. The flag writer is defined as older than a branch in the same cycle.
- Flag register: on a clock edge with stall=0, state=IDLE and flag_we=1, flags_out <= flag_in.
- Condition decode on br_cond:
  - 000 BE: taken if Z
  - 001 BLT: taken if S^V
  - 010 BLE: taken if Z | (S^V)
  - 011 BNE: taken if !Z
  - 100 B: always taken
  - 101..111: never taken (reserved)
- C does not participate in any condition; it is stored and exported only.
- State machine IDLE / FLUSH:
  - IDLE, stall=0, br_valid=1, condition true: next edge sets br_taken=1, br_pc=br_target, flush=1, busy=1, counter=FLUSH_CYCLES-1, state=FLUSH.
  - IDLE, otherwise: br_taken=0, flush=0.
  - FLUSH: br_taken=0 after its single cycle; flush=1. Counter decrements each unstalled edge. On an edge with counter=0: state=IDLE, flush=0, busy=0.
  - Total flush high time is exactly FLUSH_CYCLES unstalled cycles, starting in the cycle br_taken is high.
- Wrong-path suppression: in FLUSH, br_valid and flag_we are ignored. No flag update occurs and no new branch is taken.
- Latency: resolution is registered, one cycle from br_valid to br_taken. A not-taken branch produces no output activity.
- Stall: with stall=1, every register holds its value, including flags, state, counter, br_taken and br_pc. All inputs are ignored. Outputs remain stable across the stall.
- Simultaneous flag_we and taken branch in IDLE: flags update and the branch resolves using the new flags (BYPASS=1) or the old flags (BYPASS=0).
- Back-to-back branches: a second branch arriving the cycle after a taken branch is in FLUSH and is ignored.

Decomposition:
- Shared package simple_pkg holds:
  - flag bit index constants FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - br_cond encodings COND_BE, COND_BLT, COND_BLE, COND_BNE, COND_B
  - state enum IDLE / FLUSH
- One combinational sub-module, branch_cond_eval (flags + br_cond -> taken). It is reused by the non-pipelined core.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> flags_out=0000, br_taken=0, flush=0, busy=0. Then br_valid=1, br_cond=000 with Z=0 -> no br_taken.
- Flag latch + BE: flag_we=1, flag_in=0100 -> flags_out=0100 next cycle. br_valid=1, br_cond=000, br_target=16'h0040 -> next cycle br_taken=1, br_pc=0040. flush stays high exactly 2 cycles (FLUSH_CYCLES=2).
- BLT/BLE bypass: flags_out=0000; same cycle flag_in=1000, flag_we=1, br_cond=001, target 16'h1234 -> taken with BYPASS=1. With BYPASS=0 -> not taken, and flags_out=1000 afterwards.
- Wrong-path suppression: taken B (100) to 16'h0010, then the next cycle flag_we=1, flag_in=0100, br_valid=1, br_cond=100 -> flags_out unchanged, no second br_taken.
- Stall mid-flush: taken branch, stall=1 for 3 cycles during FLUSH -> flush, busy, counter and flags frozen. Flush deasserts after 2 total unstalled cycles.
- Reset mid-flush and reserved code: rst_n=0 while busy=1 -> flush=0 and busy=0 immediately (asynchronous). After release, br_cond=111 with any flags -> never taken.
